risc32_div: RTL

RISC32_DIV -- requirements
Module: risc32_div

---
 rtl/risc32_div.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/risc32_div.sv
// risc32_div: multi-cycle restoring divider for the EX stage.
// Handles signed (DIV) and unsigned (DIVU) operations, divide-by-zero,
// annul from flush/exception and a synchronous active-high reset.
// The result is packed as {remainder, quotient}.
module risc32_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  input  logic                 start,
  input  logic                 annul,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 stall_req
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;
  logic                 sdiv_q, sdiv_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       rem_diff;
  logic                 fits;
  assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};
  assign fits      = ~rem_diff[WIDTH];

  // Sign correction applied when the final result is loaded.
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  assign quo_fix = (sdiv_q && (s1_q ^ s2_q)) ? (WIDTH'(0) - quo_q) : quo_q;
  assign rem_fix = (sdiv_q && s1_q) ? (WIDTH'(0) - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

  // Freeze the pipeline while a divide is requested but not yet delivered.
  assign stall_req = start & ~ready_q & ~annul & ~rst;
  assign result    = result_q;
  assign ready     = ready_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    sdiv_d   = sdiv_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start && !annul) begin
          cnt_d  = '0;
          s1_d   = opdata1[WIDTH-1];
          s2_d   = opdata2[WIDTH-1];
          sdiv_d = signed_div;
          if (opdata2 == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            rem_d   = '0;
            quo_d   = (signed_div && opdata1[WIDTH-1]) ? (WIDTH'(0) - opdata1) : opdata1;
            dvs_d   = (signed_div && opdata2[WIDTH-1]) ? (WIDTH'(0) - opdata2) : opdata2;
          end
        end
      end

      BYZERO: begin
        // Zero divisor spends two cycles here so ready lands after the second edge.
        if (annul) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ON: begin
        if (annul) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end else begin
          rem_d = fits ? rem_diff : rem_shift;
          quo_d = {quo_q[WIDTH-2:0], fits};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      END: begin
        if (annul || !start) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  // State register with synchronous reset that clears all latched state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      sdiv_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      sdiv_q   <= sdiv_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

endmodule
